// File: rtl/cpu_mem_pkg.sv
// Shared constants and controller state encoding for the CPU data-memory path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_mem_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 16;
  localparam int RAM_DEPTH = 1 << ADDR_W;

  // The top two word addresses are memory-mapped I/O instead of storage.
  localparam logic [ADDR_W-1:0] PORT_IN_ADDR  = 6'h3E;
  localparam logic [ADDR_W-1:0] PORT_OUT_ADDR = 6'h3F;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_ACCESS = 2'd1,
    RD_DONE   = 2'd2,
    WR_ACCESS = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/ram_array_64x16.sv
// Single-port synchronous RAM, kept on its own so block-RAM inference stays clean.
// Latency: write commits at the clock edge; read data registered one edge after re.
// Backpressure: none; accepts one access per cycle, rdata holds between reads.
module ram_array_64x16
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  // Storage is intentionally unreset; read port is registered.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data-memory controller: 62-word RAM plus memory-mapped input and output port words.
// Latency: read data + one-cycle strobe two edges after acceptance; write commits one edge after.
// Backpressure: busy high while a request is in flight; requests seen while busy are dropped.
module data_ram_ctrl
  import cpu_mem_pkg::*;
(
  input  logic              clk_main,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_to_ram,
  input  logic [DATA_W-1:0] data_to_ram,
  input  logic              write_enable_to_ram,
  input  logic              read_enable_to_ram,
  output logic [DATA_W-1:0] data_from_ram,
  output logic              enable_ram_read,
  output logic              busy,
  output logic              conflict,
  input  logic [DATA_W-1:0] port_in,
  output logic [DATA_W-1:0] port_out
);

  ctrl_state_t       state, state_nxt;
  logic              accept_wr, accept_rd, set_conflict;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              port_sel_q;
  logic [DATA_W-1:0] port_sample_q;

  // State register; async reset also aborts any write in flight.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and request acceptance; write wins over a simultaneous read.
  always_comb begin
    state_nxt    = state;
    accept_wr    = 1'b0;
    accept_rd    = 1'b0;
    set_conflict = 1'b0;
    case (state)
      IDLE: begin
        if (write_enable_to_ram) begin
          accept_wr    = 1'b1;
          set_conflict = read_enable_to_ram;
          state_nxt    = WR_ACCESS;
        end else if (read_enable_to_ram) begin
          accept_rd = 1'b1;
          state_nxt = RD_ACCESS;
        end
      end
      RD_ACCESS: state_nxt = RD_DONE;
      RD_DONE:   state_nxt = IDLE;
      WR_ACCESS: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign ram_we = (state == WR_ACCESS) && (addr_q < PORT_IN_ADDR);
  assign ram_re = (state == RD_ACCESS);

  ram_array_64x16 u_ram (
    .clk   (clk_main),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Latch the request so the CPU may change its bus once accepted.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (accept_wr || accept_rd) begin
        addr_q <= address_to_ram;
      end
      if (accept_wr) begin
        wdata_q <= data_to_ram;
      end
    end
  end

  // Port reads are resolved alongside the array read so both sources line up in RD_DONE.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      port_sel_q    <= 1'b0;
      port_sample_q <= '0;
    end else if (state == RD_ACCESS) begin
      port_sel_q    <= (addr_q >= PORT_IN_ADDR);
      port_sample_q <= (addr_q == PORT_IN_ADDR) ? port_in : port_out;
    end
  end

  // Read result register and its one-cycle valid strobe; data holds between reads.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      data_from_ram   <= '0;
      enable_ram_read <= 1'b0;
    end else begin
      enable_ram_read <= (state == RD_DONE);
      if (state == RD_DONE) begin
        data_from_ram <= port_sel_q ? port_sample_q : ram_rdata;
      end
    end
  end

  // Output port register; writes to the input-port address fall through here unused.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      port_out <= '0;
    end else if ((state == WR_ACCESS) && (addr_q == PORT_OUT_ADDR)) begin
      port_out <= wdata_q;
    end
  end

  // Sticky record of any simultaneous read+write request.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      conflict <= 1'b0;
    end else if (set_conflict) begin
      conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl against an array-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_ram_ctrl;
  import cpu_mem_pkg::*;

  logic              clk_main = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address_to_ram;
  logic [DATA_W-1:0] data_to_ram;
  logic              write_enable_to_ram;
  logic              read_enable_to_ram;
  logic [DATA_W-1:0] data_from_ram;
  logic              enable_ram_read;
  logic              busy;
  logic              conflict;
  logic [DATA_W-1:0] port_in;
  logic [DATA_W-1:0] port_out;

  data_ram_ctrl dut (
    .clk_main            (clk_main),
    .reset               (reset),
    .address_to_ram      (address_to_ram),
    .data_to_ram         (data_to_ram),
    .write_enable_to_ram (write_enable_to_ram),
    .read_enable_to_ram  (read_enable_to_ram),
    .data_from_ram       (data_from_ram),
    .enable_ram_read     (enable_ram_read),
    .busy                (busy),
    .conflict            (conflict),
    .port_in             (port_in),
    .port_out            (port_out)
  );

  always #5 clk_main = ~clk_main;

  // Reference model: plain memory image plus port and sticky-flag state.
  logic [15:0] mem_m [64];
  logic [15:0] port_out_m;
  logic        conflict_m;
  logic [15:0] last_rd_m;
  int          checks = 0;
  int          passed = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model_read(input logic [5:0] a);
    if (a == 6'h3E) return port_in;
    if (a == 6'h3F) return port_out_m;
    return mem_m[a];
  endfunction

  task automatic model_reset();
    port_out_m = 16'h0000;
    conflict_m = 1'b0;
    last_rd_m  = 16'h0000;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk_main);
    address_to_ram      = a;
    data_to_ram         = d;
    write_enable_to_ram = 1'b1;
    @(posedge clk_main); #1;
    write_enable_to_ram = 1'b0;
    check("wr_busy_set", {15'd0, busy}, 16'd1);
    @(posedge clk_main); #1;
    if (a < 6'd62) mem_m[a] = d;
    else if (a == 6'h3F) port_out_m = d;
    check("wr_busy_clr", {15'd0, busy}, 16'd0);
    check("wr_port_out", port_out, port_out_m);
    check("wr_conflict", {15'd0, conflict}, {15'd0, conflict_m});
  endtask

  task automatic do_read(input logic [5:0] a);
    logic [15:0] exp;
    exp = model_read(a);
    @(negedge clk_main);
    address_to_ram     = a;
    read_enable_to_ram = 1'b1;
    @(posedge clk_main); #1;
    read_enable_to_ram = 1'b0;
    check("rd_busy_n1", {15'd0, busy}, 16'd1);
    check("rd_pulse_n1", {15'd0, enable_ram_read}, 16'd0);
    check("rd_hold_n1", data_from_ram, last_rd_m);
    @(posedge clk_main); #1;
    check("rd_busy_n2", {15'd0, busy}, 16'd1);
    check("rd_pulse_n2", {15'd0, enable_ram_read}, 16'd0);
    @(posedge clk_main); #1;
    check("rd_pulse", {15'd0, enable_ram_read}, 16'd1);
    check("rd_data", data_from_ram, exp);
    check("rd_busy_clr", {15'd0, busy}, 16'd0);
    last_rd_m = exp;
    @(posedge clk_main); #1;
    check("rd_pulse_end", {15'd0, enable_ram_read}, 16'd0);
    check("rd_data_hold", data_from_ram, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {15'd0, busy}, 16'd0);
    check({tag, "_pulse"}, {15'd0, enable_ram_read}, 16'd0);
    check({tag, "_data"}, data_from_ram, 16'h0000);
    check({tag, "_port_out"}, port_out, 16'h0000);
    check({tag, "_conflict"}, {15'd0, conflict}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [5:0]  ra;
    logic [15:0] rd;

    reset               = 1'b1;
    address_to_ram      = '0;
    data_to_ram         = '0;
    write_enable_to_ram = 1'b0;
    read_enable_to_ram  = 1'b0;
    port_in             = 16'h0000;
    model_reset();

    // Reset state.
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk_main);
    @(negedge clk_main) reset = 1'b1;
    #1 check_reset_outputs("rst_rel");

    // Fill the array with known random contents so every later read is predictable.
    for (int i = 0; i < 62; i++) do_write(6'(i), 16'($urandom));

    // Basic write then read.
    do_write(6'd5, 16'h1234);
    do_read(6'd5);

    // Output port write and read-back.
    do_write(6'h3F, 16'hA5A5);
    check("port_out_a5a5", port_out, 16'hA5A5);
    do_read(6'h3F);

    // Input port read; write to it is discarded.
    port_in = 16'h00FF;
    do_read(6'h3E);
    do_write(6'h3E, 16'hFFFF);
    do_read(6'h3E);

    // Simultaneous read and write: write wins, no read strobe, sticky flag.
    @(negedge clk_main);
    address_to_ram      = 6'd3;
    data_to_ram         = 16'h0042;
    write_enable_to_ram = 1'b1;
    read_enable_to_ram  = 1'b1;
    @(posedge clk_main); #1;
    write_enable_to_ram = 1'b0;
    read_enable_to_ram  = 1'b0;
    mem_m[3]   = 16'h0042;
    conflict_m = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (enable_ram_read) pulses++;
      @(posedge clk_main); #1;
    end
    check("conflict_pulses", 16'(pulses), 16'd0);
    check("conflict_sticky", {15'd0, conflict}, 16'd1);
    do_read(6'd3);

    // Read issued while busy with a write is dropped, then reissued.
    @(negedge clk_main);
    address_to_ram      = 6'd9;
    data_to_ram         = 16'h5A5A;
    write_enable_to_ram = 1'b1;
    @(posedge clk_main); #1;
    write_enable_to_ram = 1'b0;
    mem_m[9] = 16'h5A5A;
    address_to_ram      = 6'd7;
    read_enable_to_ram  = 1'b1;
    @(posedge clk_main); #1;
    read_enable_to_ram  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (enable_ram_read) pulses++;
      @(posedge clk_main); #1;
    end
    check("busy_drop_pulses", 16'(pulses), 16'd0);
    do_read(6'd7);

    // Randomised mix of reads and writes against the model.
    for (int i = 0; i < 60; i++) begin
      ra      = 6'($urandom_range(0, 63));
      rd      = 16'($urandom);
      port_in = 16'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(ra, rd);
      else do_read(ra);
    end

    // Reset during a port-out write aborts it.
    do_write(6'h3F, 16'h1111);
    @(negedge clk_main);
    address_to_ram      = 6'h3F;
    data_to_ram         = 16'hBEEF;
    write_enable_to_ram = 1'b1;
    @(posedge clk_main); #1;
    write_enable_to_ram = 1'b0;
    reset = 1'b0;
    model_reset();
    #1 check_reset_outputs("rst_wr");
    #1 reset = 1'b1;
    @(posedge clk_main); #1;
    check("rst_wr_port_out_after", port_out, 16'h0000);
    check("rst_wr_busy_after", {15'd0, busy}, 16'd0);
    do_read(6'h3F);

    // Reset during an array write leaves the old word in place.
    @(negedge clk_main);
    address_to_ram      = 6'd10;
    data_to_ram         = ~mem_m[10];
    write_enable_to_ram = 1'b1;
    @(posedge clk_main); #1;
    write_enable_to_ram = 1'b0;
    reset = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    @(posedge clk_main); #1;
    do_read(6'd10);

    // Reset during a read suppresses the strobe.
    @(negedge clk_main);
    address_to_ram     = 6'd5;
    read_enable_to_ram = 1'b1;
    @(posedge clk_main); #1;
    read_enable_to_ram = 1'b0;
    reset = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_main); #1;
      if (enable_ram_read) pulses++;
    end
    check("rst_rd_pulses", 16'(pulses), 16'd0);
    check("rst_rd_data", data_from_ram, 16'h0000);
    do_read(6'd5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/data_ram_ctrl.md
# data_ram_ctrl

Data-memory controller that sits directly downstream of the CPU's RAM port. It accepts the CPU's read/write requests over `address_to_ram`/`data_to_ram` and returns read data on `data_from_ram` with a one-cycle `enable_ram_read` valid strobe. It holds 62 words of 16-bit storage plus two memory-mapped I/O words: an input port and a latched output port. A small FSM serialises accesses and reports `busy` while a request is in flight.

## Interface
- `ADDR_W`, 6: word address width.
- `DATA_W`, 16: data word width.
- `PORT_IN_ADDR`, 6'h3E: read-only address that returns `port_in`.
- `PORT_OUT_ADDR`, 6'h3F: read/write address of the output port register.

Ports:
- `clk_main` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `address_to_ram` in ADDR_W: request word address.
- `data_to_ram` in DATA_W: write data.
- `write_enable_to_ram` in 1: write request, sampled in IDLE.
- `read_enable_to_ram` in 1: read request, sampled in IDLE.
- `data_from_ram` out DATA_W: read data. Holds its value between reads.
- `enable_ram_read` out 1: one-cycle pulse marking `data_from_ram` valid.
- `busy` out 1: high in any state other than IDLE.
- `conflict` out 1: sticky flag, set when read and write are requested together.
- `port_in` in DATA_W: external input word.
- `port_out` out DATA_W: output port register.

## Operation
- States: IDLE, RD_ACCESS, RD_DONE, WR_ACCESS.
- IDLE, write request high: latch address and data, go to WR_ACCESS.
- IDLE, read request high (write low): latch address, go to RD_ACCESS.
- IDLE, neither request: stay in IDLE.
- IDLE, read and write both high: treat as a write, drop the read, set `conflict`. `conflict` stays set until reset.
- RD_ACCESS: perform the registered array read, or select `port_in`/`port_out` by address. Go to RD_DONE.
- RD_DONE: drive `data_from_ram` from the selected source, pulse `enable_ram_read`, return to IDLE.
- WR_ACCESS: commit the write at the edge leaving this state, then return to IDLE.
  - Addresses 0–61: write the array.
  - `PORT_OUT_ADDR`: load `port_out`.
  - `PORT_IN_ADDR`: silently discard the write.
- Requests seen while `busy` is high are ignored and are not queued. The CPU must hold or reissue them.
- `port_in` is sampled during RD_ACCESS. No synchroniser; the source is assumed synchronous to `clk_main`.

## Timing
- Reset values: state IDLE; `data_from_ram`, `port_out` = 0; `enable_ram_read`, `busy`, `conflict` = 0.
- Array contents are not reset.
- Read latency: request sampled at edge N. `data_from_ram` and `enable_ram_read` are valid after edge N+2, for one cycle. `busy` is high between edges N and N+2.
- Write: sampled at edge N, committed at edge N+1. `busy` is high for one cycle.
- Back-to-back: the earliest next request acceptance is edge N+2 after a write and edge N+3 after a read.
- Read-after-write to the same address returns the new data.
- Reset asserted during WR_ACCESS aborts the write: array and `port_out` are unchanged.
- Reset asserted during RD_ACCESS or RD_DONE: no `enable_ram_read` pulse.
- Address wrap does not apply. All 64 addresses are decoded.

## Structure
- Shared package `cpu_mem_pkg` contains:
  - `ADDR_W` and `DATA_W` constants.
  - `PORT_IN_ADDR` and `PORT_OUT_ADDR` constants.
  - Controller state enum encoding.
- Sub-module `ram_array_64x16`: single-port synchronous RAM with registered read and write-enable. This lets FPGA block-RAM inference stay isolated.
- FSM, port registers and address decode live in `data_ram_ctrl`.

## Test plan
- Reset, then write 16'h1234 to address 5 and read address 5: `enable_ram_read` pulses 2 edges after the read is accepted, `data_from_ram` = 16'h1234, `busy` then returns to 0.
- Write 16'hA5A5 to 6'h3F: `port_out` = 16'hA5A5 one edge after acceptance. Reading 6'h3F returns 16'hA5A5.
- Set `port_in` = 16'h00FF and read 6'h3E: 16'h00FF is returned. A write of 16'hFFFF to 6'h3E leaves the next read at 16'h00FF.
- Assert read and write together on address 3 with data 16'h0042: `conflict` goes to 1 and stays 1, there is no `enable_ram_read` pulse, and a later read of address 3 returns 16'h0042.
- Issue a read of address 7 while `busy` is high from a prior write: the request is ignored, with exactly one `enable_ram_read` pulse only after the read is reissued in IDLE.
- Pull `reset` low during WR_ACCESS of 16'hBEEF to 6'h3F: `port_out` stays 0, all outputs read their reset values immediately, state is IDLE.
